line_fetch_ctrl: RTL and testbench
==================================

// Module: line_fetch_ctrl
// PURPOSE
//  Sequences refill of the TFT line buffer from the frame buffer in the sys_clk domain.
//  Each line_req fetches one 1280-pixel line: 320 128-bit words (4 x 32-bit pixels/word),
//  issued as fixed-length read bursts to the memory port.
//  Drives PLB_BRAM_data/PLB_BRAM_we of the line buffer. Tracks the current line index within the frame.
// PARAMETERS
//  WORDS_PER_LINE     320   128-bit words per display line; multiple of BURST_WORDS
//  BURST_WORDS        16    beats per memory read burst (bytes per burst = BURST_WORDS*16)
//  LINES_PER_FRAME    1024  display lines per frame
//  LINE_STRIDE_BYTES  8192  byte distance between consecutive line starts in memory
// PORTS
//  sys_clk        in   1    system clock
//  sys_rst        in   1    asynchronous reset, active-high
//  enable         in   1    1 = line_req honoured; 0 = new requests ignored
//  frame_base     in   32   byte address of line 0; sampled at line start
//  frame_start    in   1    1-cycle pulse: next fetched line is line 0
//  line_req       in   1    1-cycle pulse: fetch next line (sys_clk domain)
//  underrun_clr   in   1    clears underrun
//  mem_req        out  1    burst read request; held until mem_ack
//  mem_addr       out  32   burst start byte address; stable while mem_req=1
//  mem_ack        in   1    request accepted this cycle
//  mem_rd_valid   in   1    one 128-bit read beat valid this cycle
//  mem_rd_data    in   128  read beat data
//  PLB_BRAM_data  out  128  line buffer write data
//  PLB_BRAM_we    out  1    line buffer write strobe, one per word
//  busy           out  1    line fetch in progress
//  line_idx       out  10   index of the next line to fetch (0..LINES_PER_FRAME-1)
//  underrun       out  1    sticky: line_req arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0, frame-restart pending flag 0.
//  FSM states and transitions:
//   IDLE->REQ on line_req & enable. Latch line_base = frame_base + line_idx*LINE_STRIDE_BYTES.
//    Set burst_cnt=0 and word_cnt=0. busy=1 from the next cycle.
//   REQ: mem_req=1 and mem_addr = line_base + burst_cnt*BURST_WORDS*16. Both are registered.
//    On mem_ack, mem_req=0 in the next cycle and the FSM moves to DATA.
//    At most one request is outstanding. The ack cycle counts as acceptance.
//   DATA: each mem_rd_valid increments beat_cnt and word_cnt.
//    After the BURST_WORDS-th beat: if word_cnt==WORDS_PER_LINE, go to IDLE.
//    Otherwise increment burst_cnt and go to REQ. This gives 20 bursts per line with defaults.
//  Write path: PLB_BRAM_data<=mem_rd_data and PLB_BRAM_we<=mem_rd_valid (valid only in DATA).
//   Latency is 1 cycle. Exactly WORDS_PER_LINE strobes per line.
//   The line buffer write pointer wraps on its own count, so a line is never truncated or padded.
//  Line completion, on the cycle the FSM returns to IDLE:
//   if the pending flag is set, line_idx=0 and the flag is cleared;
//   otherwise line_idx increments, wrapping LINES_PER_FRAME-1 -> 0. busy=0 in the next cycle.
//  frame_start in IDLE: line_idx=0 immediately.
//  frame_start while busy: the current line completes normally and the pending flag is set.
//  frame_start with line_req in the same IDLE cycle: the fetch uses line 0.
//  line_req while busy, including the completion cycle: ignored, underrun=1.
//   underrun is cleared only by underrun_clr or sys_rst. underrun_clr and a set in the same cycle: set wins.
//  enable=0 mid-line: the current line completes, then new requests are ignored.
//   line_req with enable=0 in IDLE: ignored, no underrun.
//  mem_rd_valid outside DATA: ignored, no write strobe.
//  sys_rst mid-burst: immediate return to reset state. The memory side must be reset together.
//  Address arithmetic is 32-bit, modulo 2^32, with no overflow detection.
// TESTING
//  T1 frame_base=0x1000_0000, line_req, 0-wait ack/valid ->
//     20 requests at 0x1000_0000 + k*0x100, 320 we pulses, line_idx 0->1, busy drops.
//  T2 random mem_ack delay 0-7 and valid gaps -> mem_addr stable while mem_req=1,
//     we count = 320, data order matches beats.
//  T3 1024 consecutive lines -> line 1023 fetched at base+1023*8192; line_idx wraps to 0.
//  T4 frame_start at word 150 of line 5 -> line 5 completes (320 writes),
//     next line_req fetches from frame_base, line_idx=1 afterwards.
//  T5 line_req during fetch -> ignored, underrun=1 and held; underrun_clr -> 0; enable=0 request -> no fetch.
//  T6 sys_rst asserted in DATA -> outputs 0 asynchronously; after release, line_req fetches line 0.

Source files
------------

// File: rtl/line_fetch_ctrl.sv
// line_fetch_ctrl: refills the TFT line buffer one display line at a time.
// Each line_req reads one line from the frame buffer using fixed-length read bursts.
// Ports:
//   sys_clk, sys_rst                  clock and asynchronous active-high reset
//   enable, frame_base, frame_start   frame control inputs
//   line_req, underrun_clr            request pulse and sticky-flag clear
//   mem_req/mem_addr/mem_ack          burst read request handshake
//   mem_rd_valid/mem_rd_data          read beats returned by memory
//   PLB_BRAM_data/PLB_BRAM_we         line buffer write port
//   busy, line_idx, underrun          status outputs
module line_fetch_ctrl #(
  parameter int WORDS_PER_LINE    = 320,
  parameter int BURST_WORDS       = 16,
  parameter int LINES_PER_FRAME   = 1024,
  parameter int LINE_STRIDE_BYTES = 8192,
  parameter int LIDX_W            = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [31:0]       frame_base,
  input  logic              frame_start,
  input  logic              line_req,
  input  logic              underrun_clr,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rd_valid,
  input  logic [127:0]      mem_rd_data,
  output logic [127:0]      PLB_BRAM_data,
  output logic              PLB_BRAM_we,
  output logic              busy,
  output logic [LIDX_W-1:0] line_idx,
  output logic              underrun
);

  localparam int WC_W = $clog2(WORDS_PER_LINE + 1);
  localparam int BC_W = $clog2(BURST_WORDS + 1);
  localparam int BN_W = $clog2(WORDS_PER_LINE / BURST_WORDS + 1);

  localparam logic [31:0]       BURST_BYTES = 32'(BURST_WORDS * 16);
  localparam logic [31:0]       STRIDE      = 32'(LINE_STRIDE_BYTES);
  localparam logic [WC_W-1:0]   WPL         = WC_W'(WORDS_PER_LINE);
  localparam logic [BC_W-1:0]   BEAT_LAST   = BC_W'(BURST_WORDS - 1);
  localparam logic [LIDX_W-1:0] LINE_LAST   = LIDX_W'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         line_base_q, line_base_d;
  logic [BN_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [LIDX_W-1:0]   line_idx_q, line_idx_d;
  logic                pending_q, pending_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [127:0]        bram_data_q, bram_data_d;
  logic                bram_we_q, bram_we_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic [LIDX_W-1:0]   start_idx;

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    line_idx_d  = line_idx_q;
    pending_d   = pending_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    bram_data_d = mem_rd_data;
    bram_we_d   = 1'b0;
    underrun_d  = underrun_q;
    start_idx   = line_idx_q;

    // a request that arrives while a line is in flight sets the flag;
    // a set beats a simultaneous clear
    if (line_req && (state_q != S_IDLE)) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          start_idx  = '0;
          line_idx_d = '0;
        end
        if (line_req && enable) begin
          line_base_d = frame_base + 32'(start_idx) * STRIDE;
          burst_cnt_d = '0;
          beat_cnt_d  = '0;
          word_cnt_d  = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = line_base_d;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (mem_rd_valid) begin
          bram_we_d  = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            if (word_cnt_d == WPL) begin
              state_d = S_IDLE;
              // a restart seen during the line takes effect here
              if (pending_d) begin
                line_idx_d = '0;
                pending_d  = 1'b0;
              end else if (line_idx_q == LINE_LAST) begin
                line_idx_d = '0;
              end else begin
                line_idx_d = line_idx_q + 1'b1;
              end
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
              mem_req_d   = 1'b1;
              mem_addr_d  = line_base_q + 32'(burst_cnt_d) * BURST_BYTES;
              state_d     = S_REQ;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      line_base_q <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      line_idx_q  <= '0;
      pending_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      line_idx_q  <= line_idx_d;
      pending_q   <= pending_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign PLB_BRAM_data = bram_data_q;
  assign PLB_BRAM_we   = bram_we_q;
  assign busy          = busy_q;
  assign line_idx      = line_idx_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Testbench for line_fetch_ctrl: random-latency memory responder plus a
// line/frame reference model; prints one summary line at the end.
module tb_line_fetch_ctrl;

  localparam int LPF = 16;
  localparam int WPL = 320;
  localparam int BW  = 16;
  localparam int NB  = WPL / BW;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [31:0]  frame_base;
  logic         frame_start;
  logic         line_req;
  logic         underrun_clr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic         mem_rd_valid;
  logic [127:0] mem_rd_data;
  logic [127:0] PLB_BRAM_data;
  logic         PLB_BRAM_we;
  logic         busy;
  logic [9:0]   line_idx;
  logic         underrun;

  int checks = 0;
  int errors = 0;

  int max_dly = 0;
  int gap_pct = 0;
  bit spur_en = 0;
  int unstable = 0;
  logic [31:0]  req_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];

  int model_idx = 0;
  bit model_pend = 0;

  // frame shortened so the line index wraps within a short run
  line_fetch_ctrl #(
    .WORDS_PER_LINE(WPL),
    .BURST_WORDS(BW),
    .LINES_PER_FRAME(LPF),
    .LINE_STRIDE_BYTES(8192),
    .LIDX_W(10)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .enable(enable),
    .frame_base(frame_base),
    .frame_start(frame_start),
    .line_req(line_req),
    .underrun_clr(underrun_clr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data),
    .PLB_BRAM_data(PLB_BRAM_data),
    .PLB_BRAM_we(PLB_BRAM_we),
    .busy(busy),
    .line_idx(line_idx),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // memory responder: one burst at a time, random ack delay and beat gaps
  initial begin
    int rphase;
    int dly;
    int beats;
    rphase = 0;
    dly = 0;
    beats = 0;
    mem_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (rst) begin
        rphase = 0;
      end else begin
        case (rphase)
          0: begin
            if (mem_req) begin
              dly = $urandom_range(0, max_dly);
              if (dly == 0) begin
                mem_ack = 1'b1;
                beats = 0;
                rphase = 2;
              end else begin
                rphase = 1;
              end
            end else if (spur_en) begin
              mem_rd_valid = 1'($urandom_range(0, 1));
            end
          end
          1: begin
            dly--;
            if (dly == 0) begin
              mem_ack = 1'b1;
              beats = 0;
              rphase = 2;
            end
          end
          default: begin
            if (int'($urandom_range(0, 99)) >= gap_pct) begin
              mem_rd_valid = 1'b1;
              exp_q.push_back(mem_rd_data);
              beats++;
              if (beats == BW) rphase = 0;
            end
          end
        endcase
      end
    end
  end

  // observes line buffer writes and burst requests
  initial begin
    logic        prev_req;
    logic [31:0] prev_addr;
    prev_req = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (PLB_BRAM_we === 1'b1) got_q.push_back(PLB_BRAM_data);
      if (mem_req === 1'b1 && prev_req !== 1'b1) req_q.push_back(mem_addr);
      if (mem_req === 1'b1 && prev_req === 1'b1 && mem_addr !== prev_addr)
        unstable++;
      prev_req = mem_req;
      prev_addr = mem_addr;
    end
  end

  function automatic logic [31:0] exp_base();
    return frame_base + 32'(model_idx) * 32'd8192;
  endfunction

  function automatic void model_done();
    if (model_pend) model_idx = 0;
    else model_idx = (model_idx + 1) % LPF;
    model_pend = 0;
  endfunction

  function automatic int addr_errs(input logic [31:0] b);
    int n = 0;
    for (int k = 0; k < req_q.size(); k++)
      if (req_q[k] !== b + 32'(k) * 32'd256) n++;
    return n;
  endfunction

  function automatic int data_errs();
    int n = 0;
    if (got_q.size() != exp_q.size()) n++;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) n++;
    return n;
  endfunction

  function automatic void clear_logs();
    got_q.delete();
    exp_q.delete();
    req_q.delete();
    unstable = 0;
  endfunction

  // issue one line_req and wait for the line to finish; optional extra
  // stimulus fires at given points while the line is in flight
  task automatic do_line(input int fs_at, input int lr_at, input bit clr_too,
                         input int en_off_at, output bit to);
    bit fired;
    fired = 0;
    to = 1;
    clear_logs();
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      line_req = 1'b0;
      underrun_clr = 1'b0;
      if (!busy) begin
        to = 0;
        break;
      end
      if (fs_at >= 0 && !fired && got_q.size() >= fs_at) begin
        frame_start = 1'b1;
        fired = 1;
      end
      if (i == lr_at) begin
        line_req = 1'b1;
        underrun_clr = clr_too;
      end
      if (i == en_off_at) enable = 1'b0;
    end
    frame_start = 1'b0;
    line_req = 1'b0;
    underrun_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    frame_base = '0;
    frame_start = 1'b0;
    line_req = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b exp 0", busy);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got req %0b addr %0h exp 0", mem_req, mem_addr);
    end
    checks++;
    if (PLB_BRAM_we !== 1'b0 || PLB_BRAM_data !== 128'h0) begin
      errors++; $display("FAIL reset_bram: got we %0b data %0h exp 0", PLB_BRAM_we, PLB_BRAM_data);
    end
    checks++;
    if (line_idx !== 10'd0 || underrun !== 1'b0) begin
      errors++; $display("FAIL reset_status: got idx %0d underrun %0b exp 0", line_idx, underrun);
    end
    rst = 1'b0;
    model_idx = 0;
    model_pend = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] b;
    bit to;
    frame_base = 32'h1000_0000;
    max_dly = 0;
    gap_pct = 0;
    b = exp_base();
    do_line(-1, -1, 0, -1, to);
    model_done();
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: line did not finish"); end
    checks++;
    if (req_q.size() != NB) begin
      errors++; $display("FAIL basic_reqs: got %0d exp %0d", req_q.size(), NB);
    end
    checks++;
    if (addr_errs(b) != 0 || req_q[0] !== 32'h1000_0000) begin
      errors++; $display("FAIL basic_addr: got %0d bad, first %0h exp base %0h", addr_errs(b), req_q[0], b);
    end
    checks++;
    if (got_q.size() != WPL) begin
      errors++; $display("FAIL basic_we: got %0d exp %0d", got_q.size(), WPL);
    end
    checks++;
    if (data_errs() != 0) begin
      errors++; $display("FAIL basic_data: got %0d mismatching words exp 0", data_errs());
    end
    checks++;
    if (line_idx !== 10'(model_idx) || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idx: got idx %0d busy %0b exp %0d 0", line_idx, busy, model_idx);
    end
  endtask

  task automatic test_random_timing();
    logic [31:0] b;
    bit to;
    max_dly = 7;
    gap_pct = 30;
    spur_en = 1;
    for (int l = 0; l < 4; l++) begin
      frame_base = $urandom;
      b = exp_base();
      do_line(-1, -1, 0, -1, to);
      model_done();
      checks++;
      if (to) begin errors++; $display("FAIL rand_timeout: line %0d did not finish", l); end
      checks++;
      if (unstable != 0) begin
        errors++; $display("FAIL rand_addr_stable: got %0d changes exp 0", unstable);
      end
      checks++;
      if (req_q.size() != NB || addr_errs(b) != 0) begin
        errors++; $display("FAIL rand_addr: got %0d reqs %0d bad exp %0d 0", req_q.size(), addr_errs(b), NB);
      end
      checks++;
      if (got_q.size() != WPL || data_errs() != 0) begin
        errors++; $display("FAIL rand_data: got %0d words %0d bad exp %0d 0", got_q.size(), data_errs(), WPL);
      end
      checks++;
      if (line_idx !== 10'(model_idx)) begin
        errors++; $display("FAIL rand_idx: got %0d exp %0d", line_idx, model_idx);
      end
    end
    spur_en = 0;
    max_dly = 0;
    gap_pct = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] b;
    bit to;
    int bad_to;
    int bad_addr;
    int bad_idx;
    bad_to = 0;
    bad_addr = 0;
    bad_idx = 0;
    frame_base = 32'hFFFF_0000;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    model_idx = 0;
    checks++;
    if (line_idx !== 10'd0) begin
      errors++; $display("FAIL wrap_fs_idle: got %0d exp 0", line_idx);
    end
    b = '0;
    for (int l = 0; l < LPF; l++) begin
      b = exp_base();
      do_line(-1, -1, 0, -1, to);
      model_done();
      if (to) bad_to++;
      if (req_q.size() != NB || addr_errs(b) != 0) bad_addr++;
      if (line_idx !== 10'(model_idx)) bad_idx++;
    end
    checks++;
    if (bad_to != 0 || bad_addr != 0) begin
      errors++; $display("FAIL wrap_lines: got %0d timeouts %0d bad lines exp 0", bad_to, bad_addr);
    end
    checks++;
    if (bad_idx != 0) begin
      errors++; $display("FAIL wrap_idx_seq: got %0d bad exp 0", bad_idx);
    end
    checks++;
    if (req_q[0] !== frame_base + 32'((LPF - 1) * 8192)) begin
      errors++; $display("FAIL wrap_last_base: got %0h exp %0h", req_q[0], frame_base + 32'((LPF - 1) * 8192));
    end
    checks++;
    if (line_idx !== 10'd0) begin
      errors++; $display("FAIL wrap_idx: got %0d exp 0", line_idx);
    end
  endtask

  task automatic test_frame_restart();
    logic [31:0] b;
    bit to;
    frame_base = 32'h2000_0000;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    model_idx = 0;
    for (int l = 0; l < 5; l++) begin
      do_line(-1, -1, 0, -1, to);
      model_done();
    end
    b = exp_base();
    do_line(150, -1, 0, -1, to);
    model_pend = 1;
    model_done();
    checks++;
    if (to || got_q.size() != WPL || data_errs() != 0) begin
      errors++; $display("FAIL restart_line5: got %0d words timeout %0b exp %0d", got_q.size(), to, WPL);
    end
    checks++;
    if (req_q.size() != NB || addr_errs(b) != 0) begin
      errors++; $display("FAIL restart_line5_addr: got %0d bad exp 0", addr_errs(b));
    end
    checks++;
    if (line_idx !== 10'(model_idx)) begin
      errors++; $display("FAIL restart_idx0: got %0d exp %0d", line_idx, model_idx);
    end
    b = exp_base();
    do_line(-1, -1, 0, -1, to);
    model_done();
    checks++;
    if (to || req_q.size() != NB || addr_errs(frame_base) != 0) begin
      errors++; $display("FAIL restart_next_base: got %0h exp %0h", req_q[0], frame_base);
    end
    checks++;
    if (line_idx !== 10'(model_idx) || line_idx !== 10'd1) begin
      errors++; $display("FAIL restart_idx1: got %0d exp 1", line_idx);
    end
  endtask

  task automatic test_underrun();
    bit to;
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_init: got %0b exp 0", underrun);
    end
    do_line(-1, 30, 0, -1, to);
    model_done();
    checks++;
    if (to || underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_set: got %0b exp 1", underrun);
    end
    checks++;
    if (req_q.size() != NB || got_q.size() != WPL || line_idx !== 10'(model_idx)) begin
      errors++; $display("FAIL underrun_ignored: got %0d reqs %0d words idx %0d exp %0d %0d %0d",
                         req_q.size(), got_q.size(), line_idx, NB, WPL, model_idx);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_hold: got busy %0b underrun %0b exp 0 1", busy, underrun);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_clr: got %0b exp 0", underrun);
    end
    do_line(-1, 10, 1, -1, to);
    model_done();
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_set_wins: got %0b exp 1", underrun);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    do_line(-1, -1, 0, 20, to);
    model_done();
    checks++;
    if (to || got_q.size() != WPL || line_idx !== 10'(model_idx)) begin
      errors++; $display("FAIL enable_off_midline: got %0d words idx %0d exp %0d %0d",
                         got_q.size(), line_idx, WPL, model_idx);
    end
    clear_logs();
    spur_en = 1;
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    repeat (30) @(negedge clk);
    spur_en = 0;
    checks++;
    if (busy !== 1'b0 || req_q.size() != 0 || underrun !== 1'b0) begin
      errors++; $display("FAIL enable_off_req: got busy %0b reqs %0d underrun %0b exp 0 0 0",
                         busy, req_q.size(), underrun);
    end
    checks++;
    if (got_q.size() != 0 || line_idx !== 10'(model_idx)) begin
      errors++; $display("FAIL idle_valid: got %0d writes idx %0d exp 0 %0d", got_q.size(), line_idx, model_idx);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    bit to;
    bit reached;
    reached = 0;
    frame_base = 32'h3000_0000;
    max_dly = 2;
    gap_pct = 10;
    clear_logs();
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      line_req = (i == 5);
      if (got_q.size() >= 40) begin
        reached = 1;
        break;
      end
    end
    line_req = 1'b0;
    checks++;
    if (!reached || underrun !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup: got reached %0b underrun %0b exp 1 1", reached, underrun);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_mem: got busy %0b req %0b addr %0h exp 0", busy, mem_req, mem_addr);
    end
    checks++;
    if (PLB_BRAM_we !== 1'b0 || PLB_BRAM_data !== 128'h0) begin
      errors++; $display("FAIL rstmid_bram: got we %0b data %0h exp 0", PLB_BRAM_we, PLB_BRAM_data);
    end
    checks++;
    if (line_idx !== 10'd0 || underrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_status: got idx %0d underrun %0b exp 0 0", line_idx, underrun);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_idx = 0;
    model_pend = 0;
    max_dly = 0;
    gap_pct = 0;
    frame_base = 32'h4000_0000;
    @(negedge clk);
    b = exp_base();
    do_line(-1, -1, 0, -1, to);
    model_done();
    checks++;
    if (to || req_q.size() != NB || addr_errs(b) != 0 || req_q[0] !== 32'h4000_0000) begin
      errors++; $display("FAIL rstmid_refetch: got first %0h exp %0h", req_q[0], b);
    end
    checks++;
    if (got_q.size() != WPL || data_errs() != 0 || line_idx !== 10'd1) begin
      errors++; $display("FAIL rstmid_line: got %0d words idx %0d exp %0d 1", got_q.size(), line_idx, WPL);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_timing();
    test_wrap();
    test_frame_restart();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
